// File: rtl/reg_file_param_if.sv
// reg_file_param_if
//   Bus bundle between the control unit / ALU side and reg_file_param.
//   Clock and reset are not part of the bundle; they stay plain ports on
//   the register file.
//
//   Parameters
//     DATA_W    register width in bits
//     NUM_REGS  register count (power of two, >= 2)
//
//   Signals (direction as seen by the register file, i.e. the slave)
//     wr_en, wr_addr, wr_data    in   write port
//     ra_addr, rb_addr           in   read port addresses
//     ra_data, rb_data           out  read port data
//     rsv_en, rsv_addr           in   pending-scoreboard reservation
//     ra_pending, rb_pending     out  pending bits of the read addresses
//     clr_req                    in   request sequenced clear
//     clr_busy, clr_done         out  clear engine status
//     dbg_regs                   out  flat register image, reg i at [i*DATA_W +: DATA_W]
interface reg_file_param_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic [ADDR_W-1:0]            ra_addr;
  logic [ADDR_W-1:0]            rb_addr;
  logic [DATA_W-1:0]            ra_data;
  logic [DATA_W-1:0]            rb_data;
  logic                         rsv_en;
  logic [ADDR_W-1:0]            rsv_addr;
  logic                         ra_pending;
  logic                         rb_pending;
  logic                         clr_req;
  logic                         clr_busy;
  logic                         clr_done;
  logic [NUM_REGS*DATA_W-1:0]   dbg_regs;

  // Control unit / ALU side drives requests and observes results
  modport master (
    output wr_en, wr_addr, wr_data, ra_addr, rb_addr, rsv_en, rsv_addr, clr_req,
    input  ra_data, rb_data, ra_pending, rb_pending, clr_busy, clr_done, dbg_regs
  );

  // Register file side
  modport slave (
    input  wr_en, wr_addr, wr_data, ra_addr, rb_addr, rsv_en, rsv_addr, clr_req,
    output ra_data, rb_data, ra_pending, rb_pending, clr_busy, clr_done, dbg_regs
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param
//   Parametrised 1-write / 2-read register file with a per-register pending
//   scoreboard and a sequenced bulk-clear engine (busy/done handshake).
//
//   Parameters
//     DATA_W    register width in bits (>= 1)
//     NUM_REGS  register count, power of two, >= 2
//
//   Ports
//     clk    in   rising-edge clock for all state
//     reset  in   synchronous, active-high; overrides everything, even mid-clear
//     bus    slave modport of reg_file_param_if (write/read ports, reservation,
//            pending outputs, clear handshake, debug register image)
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, an accepted write is forwarded to a read
//                        port addressing the same register in the same cycle,
//                        and the pending outputs show the post-edge scoreboard.
//                        When undefined, reads and pending outputs show only the
//                        stored (pre-edge) contents.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  reg_file_param_if.slave   bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_post;
  logic [NUM_REGS-1:0] wr_clear;
  logic [NUM_REGS-1:0] rsv_set;
  logic [ADDR_W-1:0]   counter;
  logic                wr_accept;
  logic                rsv_accept;
  logic                clr_start;
  logic                busy;
  logic                done;

  // Request qualification. While the clear engine is sweeping, writes and
  // reservations are silently dropped; a reset cycle accepts nothing either,
  // which also keeps the bypass path from forwarding a write that never lands.
  always_comb begin
    wr_accept  = bus.wr_en  && (state != CLEAR) && !reset;
    rsv_accept = bus.rsv_en && (state != CLEAR) && !reset;
    clr_start  = (state == IDLE) && bus.clr_req;
  end

  // One-hot scoreboard updates. Set is OR-ed in after the clear so that a
  // reservation and a writeback to the same register in the same cycle leave
  // the register pending (the new reservation outlives the old writeback).
  always_comb begin
    wr_clear = '0;
    rsv_set  = '0;
    if (wr_accept)  wr_clear[bus.wr_addr]  = 1'b1;
    if (rsv_accept) rsv_set[bus.rsv_addr]  = 1'b1;
    pending_post = (pending & ~wr_clear) | rsv_set;
  end

  // Clear-engine state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Clear-engine next state and status outputs. CLEAR lasts exactly NUM_REGS
  // cycles (one register per cycle), DONE is a single-cycle pulse, and
  // clr_req outside IDLE is ignored.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) state_next = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (counter == LAST_REG) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sweep counter: zeroed when a clear starts, stepped once per CLEAR cycle.
  // It is ADDR_W wide, so after the last register it wraps back to 0 by itself.
  always_ff @(posedge clk) begin
    if (reset)                counter <= '0;
    else if (clr_start)       counter <= '0;
    else if (state == CLEAR)  counter <= counter + 1'b1;
  end

  // Register array. The sweep has priority over normal writes, although
  // wr_accept is already low in CLEAR; the explicit ordering makes the intent
  // obvious.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[counter] <= '0;
    end else if (wr_accept) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Pending scoreboard. Starting a clear wipes every pending bit at once;
  // during the sweep itself nothing can be reserved or written back.
  always_ff @(posedge clk) begin
    if (reset)          pending <= '0;
    else if (clr_start) pending <= '0;
    else                pending <= pending_post;
  end

  // Read ports and pending outputs.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    bus.ra_data    = (wr_accept && (bus.wr_addr == bus.ra_addr)) ? bus.wr_data : regs[bus.ra_addr];
    bus.rb_data    = (wr_accept && (bus.wr_addr == bus.rb_addr)) ? bus.wr_data : regs[bus.rb_addr];
    bus.ra_pending = pending_post[bus.ra_addr];
    bus.rb_pending = pending_post[bus.rb_addr];
`else
    bus.ra_data    = regs[bus.ra_addr];
    bus.rb_data    = regs[bus.rb_addr];
    bus.ra_pending = pending[bus.ra_addr];
    bus.rb_pending = pending[bus.rb_addr];
`endif
    bus.clr_busy   = busy;
    bus.clr_done   = done;
  end

  // Flat debug image of the whole array.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg
    assign bus.dbg_regs[g*DATA_W +: DATA_W] = regs[g];
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param
//   Self-checking bench for reg_file_param. The default 8x8 instance is
//   compared every cycle against a behavioural model (arrays plus a count of
//   registers still to be cleared); a second 32x16 instance exercises the
//   wider parameter set with directed steps. Honours REGFILE_BYPASS_EN.
module tb_reg_file_param;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(8), .NUM_REGS(8)) bus ();
  reg_file_param #(.DATA_W(8), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  reg_file_param_if #(.DATA_W(16), .NUM_REGS(32)) bus32 ();
  reg_file_param #(.DATA_W(16), .NUM_REGS(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  // Behavioural model of the 8x8 instance
  logic [7:0] m_regs [8];
  logic [7:0] m_pend;
  int         m_remaining;
  bit         m_done;

  // Compare one observation against its expected value
  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected read value for an address, given the model and current inputs
  function automatic logic [7:0] expRead(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && m_remaining == 0 && !reset && bus.wr_addr == a) return bus.wr_data;
`endif
    return m_regs[a];
  endfunction

  // Expected pending bit for an address
  function automatic logic expPend(input logic [2:0] a);
    logic [7:0] p;
    p = m_pend;
`ifdef REGFILE_BYPASS_EN
    if (m_remaining == 0 && !reset) begin
      if (bus.wr_en)  p[bus.wr_addr]  = 1'b0;
      if (bus.rsv_en) p[bus.rsv_addr] = 1'b1;
    end
`endif
    return p[a];
  endfunction

  function automatic logic [63:0] expDbg();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  // Check every output of the 8x8 instance against the model
  task automatic checkAll();
    checkOutput("ra_data",    512'(bus.ra_data),    512'(expRead(bus.ra_addr)));
    checkOutput("rb_data",    512'(bus.rb_data),    512'(expRead(bus.rb_addr)));
    checkOutput("ra_pending", 512'(bus.ra_pending), 512'(expPend(bus.ra_addr)));
    checkOutput("rb_pending", 512'(bus.rb_pending), 512'(expPend(bus.rb_addr)));
    checkOutput("clr_busy",   512'(bus.clr_busy),   512'(m_remaining > 0));
    checkOutput("clr_done",   512'(bus.clr_done),   512'(m_done));
    checkOutput("dbg_regs",   512'(bus.dbg_regs),   512'(expDbg()));
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelEdge();
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_pend      = 8'h00;
      m_remaining = 0;
      m_done      = 1'b0;
    end else if (m_remaining > 0) begin
      m_regs[8 - m_remaining] = 8'h00;
      m_remaining--;
      m_done = (m_remaining == 0);
    end else begin
      if (bus.wr_en) m_regs[bus.wr_addr] = bus.wr_data;
      if (!m_done && bus.clr_req) begin
        m_pend      = 8'h00;
        m_remaining = 8;
      end else begin
        if (bus.wr_en)  m_pend[bus.wr_addr]  = 1'b0;
        if (bus.rsv_en) m_pend[bus.rsv_addr] = 1'b1;
      end
      m_done = 1'b0;
    end
  endtask

  // Drive one cycle of inputs (just after a falling edge), settle, check
  task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] wa,
                               input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                               input logic rs, input logic [2:0] rsa, input logic clr);
    reset        = rst;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.ra_addr  = ra;
    bus.rb_addr  = rb;
    bus.rsv_en   = rs;
    bus.rsv_addr = rsa;
    bus.clr_req  = clr;
    #1;
    checkAll();
  endtask

  // Clock edge: update the model, return at the following falling edge
  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    // Power-up: inputs idle, reset held for one edge
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.ra_addr = 0; bus.rb_addr = 0;
    bus.rsv_en = 0; bus.rsv_addr = 0; bus.clr_req = 0;
    bus32.wr_en = 0; bus32.wr_addr = 0; bus32.wr_data = 0; bus32.ra_addr = 0; bus32.rb_addr = 0;
    bus32.rsv_en = 0; bus32.rsv_addr = 0; bus32.clr_req = 0;
    @(negedge clk);
    tick();

    // Reset state
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd0, 3'd7, 0, 3'd0, 0);
    checkOutput("reset_dbg", 512'(bus.dbg_regs), 512'(0));

    // Test 1: write R3 = 0xA5, read both ports next cycle
    $display("[TB] write/read R3");
    applyStimulus(0, 1, 3'd3, 8'hA5, 3'd0, 3'd0, 0, 3'd0, 0);
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd3, 3'd3, 0, 3'd0, 0);
    checkOutput("t1_ra", 512'(bus.ra_data), 512'(8'hA5));
    checkOutput("t1_rb", 512'(bus.rb_data), 512'(8'hA5));
    checkOutput("t1_dbg", 512'(bus.dbg_regs[31:24]), 512'(8'hA5));
    tick();

    // Test 2: write R5 = 0x3C while reading R5 in the same cycle
    $display("[TB] same-cycle write/read R5");
    applyStimulus(0, 1, 3'd5, 8'h3C, 3'd5, 3'd3, 0, 3'd0, 0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("t2_same", 512'(bus.ra_data), 512'(8'h3C));
`else
    checkOutput("t2_same", 512'(bus.ra_data), 512'(8'h00));
`endif
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd5, 3'd5, 0, 3'd0, 0);
    checkOutput("t2_next", 512'(bus.ra_data), 512'(8'h3C));
    tick();

    // Test 3: pending scoreboard on R2
    $display("[TB] pending scoreboard");
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd2, 3'd2, 1, 3'd2, 0);
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd2, 3'd4, 0, 3'd0, 0);
    checkOutput("t3_rsv", 512'(bus.ra_pending), 512'(1'b1));
    tick();
    applyStimulus(0, 1, 3'd2, 8'h11, 3'd2, 3'd2, 1, 3'd2, 0);
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd2, 3'd2, 0, 3'd0, 0);
    checkOutput("t3_setwins", 512'(bus.ra_pending), 512'(1'b1));
    tick();
    applyStimulus(0, 1, 3'd2, 8'h22, 3'd2, 3'd6, 1, 3'd6, 0);
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd2, 3'd6, 0, 3'd0, 0);
    checkOutput("t3_wrclr", 512'(bus.ra_pending), 512'(1'b0));
    checkOutput("t3_other", 512'(bus.rb_pending), 512'(1'b1));
    tick();

    // Test 4: load 1..8, sequenced clear, write to R1 dropped while busy
    $display("[TB] sequenced clear");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'(i), 8'(i + 1), 3'(i), 3'd0, 0, 3'd0, 0);
      tick();
    end
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd7, 3'd6, 0, 3'd0, 1);
    tick();
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, c == 2, 3'd1, 8'hFF, 3'(c), 3'd1, c == 3, 3'd4, c == 4);
      busy_cnt += int'(bus.clr_busy);
      done_cnt += int'(bus.clr_done);
      tick();
    end
    checkOutput("t4_busy_cycles", 512'(busy_cnt), 512'(8));
    checkOutput("t4_done_pulses", 512'(done_cnt), 512'(1));
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd1, 3'd2, 0, 3'd0, 0);
    checkOutput("t4_r1", 512'(bus.ra_data), 512'(8'h00));
    checkOutput("t4_dbg", 512'(bus.dbg_regs), 512'(0));
    checkOutput("t4_pend", 512'(bus.rb_pending), 512'(1'b0));
    tick();

    // Test 5: reset on the third CLEAR cycle
    $display("[TB] reset mid-clear");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'(i), 8'(8'h40 + i), 3'(i), 3'd0, 1, 3'(i), 0);
      tick();
    end
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd0, 3'd7, 0, 3'd0, 1);
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd0, 3'd7, 0, 3'd0, 0);
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd0, 3'd7, 0, 3'd0, 0);
    tick();
    applyStimulus(1, 0, 3'd0, 8'h00, 3'd0, 3'd7, 0, 3'd0, 0);
    tick();
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd7, 3'd5, 0, 3'd0, 0);
    checkOutput("t5_busy", 512'(bus.clr_busy), 512'(1'b0));
    checkOutput("t5_dbg", 512'(bus.dbg_regs), 512'(0));
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      applyStimulus(0, 0, 3'd0, 8'h00, 3'(c), 3'd0, 0, 3'd0, 0);
      done_cnt += int'(bus.clr_done);
    end
    checkOutput("t5_no_done", 512'(done_cnt), 512'(0));
    tick();

    // Randomised traffic against the model
    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom), 3'($urandom), 8'($urandom),
                    3'($urandom), 3'($urandom), $urandom_range(0, 2) == 0, 3'($urandom),
                    $urandom_range(0, 29) == 0);
      tick();
    end

    // Test 6: 32 x 16 instance
    $display("[TB] 32x16 instance");
    applyStimulus(0, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0);
    bus32.wr_en   = 1'b1;
    bus32.wr_addr = 5'd31;
    bus32.wr_data = 16'hBEEF;
    tick();
    bus32.wr_en   = 1'b0;
    bus32.ra_addr = 5'd31;
    bus32.rb_addr = 5'd0;
    #1;
    checkOutput("t6_r31", 512'(bus32.ra_data), 512'(16'hBEEF));
    checkOutput("t6_dbg31", 512'(bus32.dbg_regs[511:496]), 512'(16'hBEEF));
    bus32.clr_req = 1'b1;
    tick();
    bus32.clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      busy_cnt += int'(bus32.clr_busy);
      done_cnt += int'(bus32.clr_done);
      tick();
    end
    #1;
    checkOutput("t6_busy_cycles", 512'(busy_cnt), 512'(32));
    checkOutput("t6_done_pulses", 512'(done_cnt), 512'(1));
    checkOutput("t6_r31_cleared", 512'(bus32.ra_data), 512'(16'h0000));
    checkOutput("t6_dbg", 512'(bus32.dbg_regs), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
